// File: rtl/pong_pkg.sv
// Shared encodings, key codes and defaults for the pong game controller.
package pong_pkg;

    localparam int unsigned WinScoreDef   = 7;
    localparam int unsigned HoldFramesDef = 120;

    localparam logic [2:0] ModeIdle   = 3'b000;
    localparam logic [2:0] ModeEasy   = 3'b001;
    localparam logic [2:0] ModeMedium = 3'b010;
    localparam logic [2:0] ModeHard   = 3'b011;
    localparam logic [2:0] ModeAi     = 3'b100;

    localparam logic [1:0] ScreenMenu  = 2'b00;
    localparam logic [1:0] ScreenPlay  = 2'b01;
    localparam logic [1:0] ScreenP1Win = 2'b10;
    localparam logic [1:0] ScreenP2Win = 2'b11;

    localparam logic [1:0] WinnerNone = 2'b00;
    localparam logic [1:0] WinnerP1   = 2'b01;
    localparam logic [1:0] WinnerP2   = 2'b10;

    localparam logic [7:0] KeyCode1     = 8'h1E;
    localparam logic [7:0] KeyCode2     = 8'h1F;
    localparam logic [7:0] KeyCode3     = 8'h20;
    localparam logic [7:0] KeyCode4     = 8'h21;
    localparam logic [7:0] KeyCodeSpace = 8'h2C;
    localparam logic [7:0] KeyCodeEsc   = 8'h29;

    typedef enum logic [1:0] {StMenu, StPlay, StP1Win, StP2Win} state_e;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Keyboard/score inputs and mode/screen outputs of the game controller.
interface pong_game_ctrl_if;

    logic [31:0] keycode;
    logic        valid;
    logic [8:0]  Score1;
    logic [8:0]  Score2;
    logic [2:0]  Mode;
    logic [1:0]  Screen;
    logic [1:0]  Winner;

    modport master (
        output keycode, valid, Score1, Score2,
        input  Mode, Screen, Winner
    );

    modport slave (
        input  keycode, valid, Score1, Score2,
        output Mode, Screen, Winner
    );

endinterface

// File: rtl/key_edge_detect.sv
// One-cycle press pulse for a single HID key code found in any of four key bytes.
module key_edge_detect #(
    parameter logic [7:0] KEY_CODE = 8'h00
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        valid,
    output logic        press
);

    logic held;
    logic held_q;

    always_comb begin
        held = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (valid && (keycode[8*b +: 8] == KEY_CODE)) begin
                held = 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            held_q <= 1'b0;
        end else begin
            held_q <= held;
        end
    end

    assign press = held & ~held_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Menu / play / win-screen controller driving the play-field mode from keyboard presses.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = WinScoreDef,
    parameter int unsigned HOLD_FRAMES = HoldFramesDef
) (
    input  logic      frame_clk,
    input  logic      Reset,
    pong_game_ctrl_if.slave bus
);

    localparam logic [8:0] WinScoreW = 9'(WIN_SCORE);
    localparam logic [7:0] HoldLast  = 8'(HOLD_FRAMES - 1);

    logic press_1, press_2, press_3, press_4, press_space, press_esc;

    state_e     state_q, state_d;
    logic [2:0] sel_mode_q, sel_mode_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] mode_q, mode_d;
    logic [1:0] screen_q, screen_d;
    logic [1:0] winner_q, winner_d;
    logic       hold_done;
    logic       in_win;

    key_edge_detect #(.KEY_CODE(KeyCode1)) u_key_1 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(bus.keycode), .valid(bus.valid),
        .press(press_1)
    );
    key_edge_detect #(.KEY_CODE(KeyCode2)) u_key_2 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(bus.keycode), .valid(bus.valid),
        .press(press_2)
    );
    key_edge_detect #(.KEY_CODE(KeyCode3)) u_key_3 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(bus.keycode), .valid(bus.valid),
        .press(press_3)
    );
    key_edge_detect #(.KEY_CODE(KeyCode4)) u_key_4 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(bus.keycode), .valid(bus.valid),
        .press(press_4)
    );
    key_edge_detect #(.KEY_CODE(KeyCodeSpace)) u_key_space (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(bus.keycode), .valid(bus.valid),
        .press(press_space)
    );
    key_edge_detect #(.KEY_CODE(KeyCodeEsc)) u_key_esc (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(bus.keycode), .valid(bus.valid),
        .press(press_esc)
    );

    assign hold_done = (hold_q == HoldLast);
    assign in_win    = (state_q == StP1Win) || (state_q == StP2Win);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StMenu;
            sel_mode_q <= ModeEasy;
            hold_q     <= '0;
            mode_q     <= ModeIdle;
            screen_q   <= ScreenMenu;
            winner_q   <= WinnerNone;
        end else begin
            state_q    <= state_d;
            sel_mode_q <= sel_mode_d;
            hold_q     <= hold_d;
            mode_q     <= mode_d;
            screen_q   <= screen_d;
            winner_q   <= winner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_mode_d = sel_mode_q;
        unique case (state_q)
            StMenu: begin
                // Lowest digit wins when several are pressed together
                if (press_1) begin
                    sel_mode_d = ModeEasy;
                    state_d    = StPlay;
                end else if (press_2) begin
                    sel_mode_d = ModeMedium;
                    state_d    = StPlay;
                end else if (press_3) begin
                    sel_mode_d = ModeHard;
                    state_d    = StPlay;
                end else if (press_4) begin
                    sel_mode_d = ModeAi;
                    state_d    = StPlay;
                end
            end
            StPlay: begin
                if (press_esc) begin
                    state_d = StMenu;
                end else if (bus.Score1 >= WinScoreW) begin
                    state_d = StP1Win;
                end else if (bus.Score2 >= WinScoreW) begin
                    state_d = StP2Win;
                end
            end
            StP1Win, StP2Win: begin
                if (press_esc || (press_space && hold_done)) begin
                    state_d = StMenu;
                end
            end
            default: state_d = StMenu;
        endcase

        // Counter restarts on every entry into a win screen and saturates at the last frame
        if (in_win && (state_d == state_q)) begin
            hold_d = hold_done ? hold_q : hold_q + 8'd1;
        end else begin
            hold_d = '0;
        end
    end

    // Outputs decoded from the next state so they switch on the same edge as the state
    always_comb begin
        mode_d   = ModeIdle;
        screen_d = ScreenMenu;
        winner_d = WinnerNone;
        unique case (state_d)
            StPlay: begin
                mode_d   = sel_mode_d;
                screen_d = ScreenPlay;
            end
            StP1Win: begin
                screen_d = ScreenP1Win;
                winner_d = WinnerP1;
            end
            StP2Win: begin
                screen_d = ScreenP2Win;
                winner_d = WinnerP2;
            end
            default: ;
        endcase
    end

    assign bus.Mode   = mode_q;
    assign bus.Screen = screen_q;
    assign bus.Winner = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: score at which a player wins.
REQ-002 Parameter HOLD_FRAMES, default 120: frames the win screen is held before Space is accepted.
REQ-003 frame_clk  input  1  clock; one tick per video frame.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 keycode  input  32  four USB HID key bytes, [7:0] through [31:24].
REQ-006 valid  input  1  qualifies keycode; treat keycode as 0 when low.
REQ-007 Score1, Score2  input  9 each  scores from the downstream play-field block.
REQ-008 Mode  output  3  play-field mode: 000 idle/clear, 001 easy, 010 medium, 011 hard, 100 AI.
REQ-009 Screen  output  2  00 menu, 01 playing, 10 player-1 win, 11 player-2 win.
REQ-010 Winner  output  2  00 none, 01 player 1, 10 player 2.

Function
REQ-011 Key match: a key counts as held when valid=1 and any of the four keycode bytes equals its code. Codes: '1'=0x1E, '2'=0x1F, '3'=0x20, '4'=0x21, Space=0x2C, Esc=0x29.
REQ-012 Key press: asserted for exactly one cycle, on the first frame_clk edge where the key is held and was not held on the previous edge. The held-history register updates every cycle.
REQ-013 FSM states: MENU, PLAY, P1WIN, P2WIN, all registered.
REQ-014 MENU: a '1'/'2'/'3'/'4' press latches sel_mode to 001/010/011/100 and goes to PLAY on the next edge.
REQ-015 MENU: if several digit presses occur in one cycle, the lowest digit wins.
REQ-016 MENU: Space and Esc are ignored.
REQ-017 PLAY: Mode=sel_mode.
REQ-018 PLAY: Score1>=WIN_SCORE goes to P1WIN; else Score2>=WIN_SCORE goes to P2WIN. When both are true, player 1 has priority.
REQ-019 PLAY: an Esc press goes to MENU and takes priority over win detection in the same cycle.
REQ-020 PLAY: digit presses are ignored; sel_mode is stable for the whole game.
REQ-021 P1WIN/P2WIN: hold_cnt (8-bit) clears on entry, then increments each cycle and saturates at HOLD_FRAMES-1. hold_done = (hold_cnt == HOLD_FRAMES-1).
REQ-022 P1WIN/P2WIN: a Space press with hold_done=1 goes to MENU. A Space press before hold_done is discarded; it is not queued.
REQ-023 P1WIN/P2WIN: an Esc press goes to MENU regardless of hold_done.
REQ-024 Mode=000 in MENU, P1WIN and P2WIN; this clears the play field every frame.
REQ-025 Screen and Winner are registered decodes of the state and change on the same edge as the state. Winner=01 only in P1WIN and 10 only in P2WIN.
REQ-026 Latency: key press edge to Mode change is 1 frame_clk; a score reaching WIN_SCORE to Mode=000 is 1 frame_clk.
REQ-027 Mode, Screen and Winner are glitch-free register outputs with no combinational path from inputs.

Reset
REQ-028 Reset=1 forces state MENU, Mode=000, Screen=00, Winner=00, sel_mode=001, hold_cnt=0 and key history all-zero, asynchronously.
REQ-029 Reset asserted mid-game or mid-hold aborts immediately, with no win reported.
REQ-030 The first edge after release samples keys with an empty history, so a key held through reset registers a press on that edge.

Structure
REQ-031 Package pong_pkg holds the Mode encodings, the Screen/Winner encodings, the state enum, the key-code constants, and the WIN_SCORE/HOLD_FRAMES defaults.
REQ-032 Sub-module key_edge_detect (parameter KEY_CODE; ports frame_clk, Reset, keycode, valid, press) is instantiated six times, once per key.

Verification
REQ-033 Reset, then '2' held 3 frames -> exactly one press; Mode 000->010 and Screen 00->01 one edge after the press.
REQ-034 In PLAY, with WIN_SCORE=7, drive Score1=7 -> next edge Mode=000, Screen=10, Winner=01.
REQ-035 In P2WIN, Space pressed at hold_cnt=50 -> state stays P2WIN. Space released, then pressed after hold_done -> MENU, Winner=00.
REQ-036 In MENU, '3' and '1' pressed in the same cycle -> Mode=001.
REQ-037 In PLAY, Esc pressed in the same cycle Score2 reaches 7 -> MENU, Winner=00.
REQ-038 Assert Reset while in P1WIN; release it with Space held -> MENU, all outputs 0, and the Space press is ignored in MENU.
